// File: rtl/operand_fetch_pkg.sv
// Shared definitions for operand delivery and writeback data selection:
// writeback source encodings, register-address width and data width.
package operand_fetch_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    SRC_ALU = 2'b00,
    SRC_MEM = 2'b01,
    SRC_PC4 = 2'b10
  } db_src_e;

  // Encoding 11 is not a load, so it falls through to ALU like every other non-01 value
  function automatic logic is_load_src(input logic [1:0] src);
    return (src == SRC_MEM);
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Pipeline-side bundle for operand_fetch: ID request, EX/MEM/WB in-flight
// results, and the forwarded operands, stall flag and stall counter.
interface operand_fetch_if;
  import operand_fetch_pkg::*;

  logic [REG_AW-1:0] ID_rs;
  logic [REG_AW-1:0] ID_rt;
  logic              ID_UseRs;
  logic              ID_UseRt;

  logic              EX_RegWre;
  logic [REG_AW-1:0] EX_WriteReg;
  logic [1:0]        EX_DBDataSrc;
  logic [XLEN-1:0]   EX_ALUResult;
  logic [XLEN-1:0]   EX_PCadd4;

  logic              MEM_RegWre;
  logic [REG_AW-1:0] MEM_WriteReg;
  logic [1:0]        MEM_DBDataSrc;
  logic [XLEN-1:0]   MEM_ALUResult;
  logic [XLEN-1:0]   MEM_PCadd4;
  logic [XLEN-1:0]   MEM_MemData;

  logic              WB_RegWre;
  logic [REG_AW-1:0] WB_WriteReg;
  logic [XLEN-1:0]   WB_WriteData;

  logic [XLEN-1:0]   ReadData1;
  logic [XLEN-1:0]   ReadData2;
  logic              Stall;
  logic [31:0]       StallCount;

  modport master (
    output ID_rs, ID_rt, ID_UseRs, ID_UseRt,
    output EX_RegWre, EX_WriteReg, EX_DBDataSrc, EX_ALUResult, EX_PCadd4,
    output MEM_RegWre, MEM_WriteReg, MEM_DBDataSrc, MEM_ALUResult, MEM_PCadd4, MEM_MemData,
    output WB_RegWre, WB_WriteReg, WB_WriteData,
    input  ReadData1, ReadData2, Stall, StallCount
  );

  modport slave (
    input  ID_rs, ID_rt, ID_UseRs, ID_UseRt,
    input  EX_RegWre, EX_WriteReg, EX_DBDataSrc, EX_ALUResult, EX_PCadd4,
    input  MEM_RegWre, MEM_WriteReg, MEM_DBDataSrc, MEM_ALUResult, MEM_PCadd4, MEM_MemData,
    input  WB_RegWre, WB_WriteReg, WB_WriteData,
    output ReadData1, ReadData2, Stall, StallCount
  );

endinterface

// File: rtl/operand_fetch_reg_array.sv
// General-purpose register storage: two asynchronous read ports, one
// synchronous write port, synchronous active-low clear, register 0 reads zero.
module reg_array #(
  parameter int NREG = 32,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr1,
  input  logic [AW-1:0]   i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] r_regs [NREG];

  // Clear has priority, so a write landing on the reset edge is dropped
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];

endmodule

// File: rtl/operand_fetch.sv
// Decode-stage operand delivery: register file plus EX/MEM/WB forwarding,
// load-use hazard detection and a saturating stall-cycle counter.
module operand_fetch #(
  parameter int NREG = 32,
  parameter int XLEN = operand_fetch_pkg::XLEN
) (
  input  logic           CLK,
  input  logic           RST_n,
  operand_fetch_if.slave bus
);
  import operand_fetch_pkg::*;

  logic [REG_AW-1:0] w_src_addr [2];
  logic [XLEN-1:0]   w_arr_data [2];
  logic [XLEN-1:0]   w_operand  [2];
  logic              w_stall;
  logic [31:0]       r_stall_count;

  assign w_src_addr[0] = bus.ID_rs;
  assign w_src_addr[1] = bus.ID_rt;

  reg_array #(.NREG(NREG), .XLEN(XLEN), .AW(REG_AW)) u_reg_array (
    .i_clk    (CLK),
    .i_rst_n  (RST_n),
    .i_we     (bus.WB_RegWre),
    .i_waddr  (bus.WB_WriteReg),
    .i_wdata  (bus.WB_WriteData),
    .i_raddr1 (w_src_addr[0]),
    .i_raddr2 (w_src_addr[1]),
    .o_rdata1 (w_arr_data[0]),
    .o_rdata2 (w_arr_data[1])
  );

  // Youngest producer wins; an EX load is not forwardable and is covered by the stall
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_operand[p] = w_arr_data[p];
      if (w_src_addr[p] == '0) begin
        w_operand[p] = '0;
      end else if (bus.EX_RegWre && (bus.EX_WriteReg == w_src_addr[p]) &&
                   !is_load_src(bus.EX_DBDataSrc)) begin
        w_operand[p] = (bus.EX_DBDataSrc == SRC_PC4) ? bus.EX_PCadd4 : bus.EX_ALUResult;
      end else if (bus.MEM_RegWre && (bus.MEM_WriteReg == w_src_addr[p])) begin
        case (bus.MEM_DBDataSrc)
          SRC_PC4: w_operand[p] = bus.MEM_PCadd4;
          SRC_MEM: w_operand[p] = bus.MEM_MemData;
          default: w_operand[p] = bus.MEM_ALUResult;
        endcase
      end else if (bus.WB_RegWre && (bus.WB_WriteReg == w_src_addr[p])) begin
        w_operand[p] = bus.WB_WriteData;
      end else begin
        w_operand[p] = w_arr_data[p];
      end
    end
  end

  assign w_stall = bus.EX_RegWre && is_load_src(bus.EX_DBDataSrc) &&
                   (bus.EX_WriteReg != '0) &&
                   ((bus.ID_UseRs && (bus.ID_rs == bus.EX_WriteReg)) ||
                    (bus.ID_UseRt && (bus.ID_rt == bus.EX_WriteReg)));

  // Stall-cycle counter, sticks at all-ones
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_stall_count <= 32'd0;
    end else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign bus.ReadData1  = w_operand[0];
  assign bus.ReadData2  = w_operand[1];
  assign bus.Stall      = w_stall;
  assign bus.StallCount = r_stall_count;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios followed by
// randomized pipeline traffic compared against a register-file model.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic CLK = 1'b0;
  logic RST_n = 1'b0;
  always #5 CLK = ~CLK;

  operand_fetch_if ifc ();

  operand_fetch #(.NREG(32), .XLEN(32)) dut (
    .CLK   (CLK),
    .RST_n (RST_n),
    .bus   (ifc)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] mdl_regs [32];
  logic [31:0] mdl_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected operand from the pipeline rules: zero reg, younger stages first, then storage
  function automatic logic [31:0] exp_op(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (ifc.EX_RegWre && ifc.EX_WriteReg == a && ifc.EX_DBDataSrc != 2'b01)
      return (ifc.EX_DBDataSrc == 2'b10) ? ifc.EX_PCadd4 : ifc.EX_ALUResult;
    if (ifc.MEM_RegWre && ifc.MEM_WriteReg == a) begin
      if (ifc.MEM_DBDataSrc == 2'b10) return ifc.MEM_PCadd4;
      if (ifc.MEM_DBDataSrc == 2'b01) return ifc.MEM_MemData;
      return ifc.MEM_ALUResult;
    end
    if (ifc.WB_RegWre && ifc.WB_WriteReg == a) return ifc.WB_WriteData;
    return mdl_regs[a];
  endfunction

  function automatic logic exp_stall();
    if (!(ifc.EX_RegWre && ifc.EX_DBDataSrc == 2'b01 && ifc.EX_WriteReg != 5'd0)) return 1'b0;
    return (ifc.ID_UseRs && ifc.ID_rs == ifc.EX_WriteReg) ||
           (ifc.ID_UseRt && ifc.ID_rt == ifc.EX_WriteReg);
  endfunction

  task automatic clear_inputs();
    ifc.ID_rs = 5'd0; ifc.ID_rt = 5'd0; ifc.ID_UseRs = 1'b0; ifc.ID_UseRt = 1'b0;
    ifc.EX_RegWre = 1'b0; ifc.EX_WriteReg = 5'd0; ifc.EX_DBDataSrc = 2'b00;
    ifc.EX_ALUResult = 32'd0; ifc.EX_PCadd4 = 32'd0;
    ifc.MEM_RegWre = 1'b0; ifc.MEM_WriteReg = 5'd0; ifc.MEM_DBDataSrc = 2'b00;
    ifc.MEM_ALUResult = 32'd0; ifc.MEM_PCadd4 = 32'd0; ifc.MEM_MemData = 32'd0;
    ifc.WB_RegWre = 1'b0; ifc.WB_WriteReg = 5'd0; ifc.WB_WriteData = 32'd0;
  endtask

  // Check current combinational outputs, then clock and advance the model
  task automatic step();
    logic s;
    #2;
    s = exp_stall();
    check_eq("stall", {31'd0, ifc.Stall}, {31'd0, s});
    check_eq("stall_count", ifc.StallCount, mdl_cnt);
    if (!s) begin
      check_eq("rd1", ifc.ReadData1, exp_op(ifc.ID_rs));
      check_eq("rd2", ifc.ReadData2, exp_op(ifc.ID_rt));
    end
    @(posedge CLK);
    if (!RST_n) begin
      for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
      mdl_cnt = 32'd0;
    end else begin
      if (ifc.WB_RegWre && ifc.WB_WriteReg != 5'd0) mdl_regs[ifc.WB_WriteReg] = ifc.WB_WriteData;
      if (s && mdl_cnt != 32'hFFFF_FFFF) mdl_cnt = mdl_cnt + 32'd1;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl_regs[i] = 32'd0;
    mdl_cnt = 32'd0;
    clear_inputs();
    RST_n = 1'b0;
    @(posedge CLK); #1;
    ifc.ID_rs = 5'd5; ifc.ID_rt = 5'd31;
    step();
    RST_n = 1'b1;
    #1;
    check_eq("reset_rd1", ifc.ReadData1, 32'd0);
    check_eq("reset_cnt", ifc.StallCount, 32'd0);
    step();

    // Write r5 then read back from the array
    ifc.WB_RegWre = 1'b1; ifc.WB_WriteReg = 5'd5; ifc.WB_WriteData = 32'h1234_5678;
    step();
    clear_inputs(); ifc.ID_rs = 5'd5;
    #1; check_eq("r5_read", ifc.ReadData1, 32'h1234_5678);
    step();
    ifc.WB_RegWre = 1'b1; ifc.WB_WriteReg = 5'd0; ifc.WB_WriteData = 32'hFFFF_FFFF;
    ifc.ID_rs = 5'd0;
    #1; check_eq("r0_bypass", ifc.ReadData1, 32'd0);
    step();
    clear_inputs();
    #1; check_eq("r0_read", ifc.ReadData1, 32'd0);
    step();

    // Same-cycle write-through on the rt port
    ifc.WB_RegWre = 1'b1; ifc.WB_WriteReg = 5'd7; ifc.WB_WriteData = 32'hA5A5_A5A5;
    ifc.ID_rt = 5'd7;
    #1; check_eq("r7_bypass", ifc.ReadData2, 32'hA5A5_A5A5);
    step();

    // Priority EX > MEM > WB
    clear_inputs(); ifc.ID_rs = 5'd3;
    ifc.EX_RegWre = 1'b1; ifc.EX_WriteReg = 5'd3; ifc.EX_ALUResult = 32'h11;
    ifc.MEM_RegWre = 1'b1; ifc.MEM_WriteReg = 5'd3; ifc.MEM_ALUResult = 32'h22;
    ifc.WB_RegWre = 1'b1; ifc.WB_WriteReg = 5'd3; ifc.WB_WriteData = 32'h33;
    #1; check_eq("prio_ex", ifc.ReadData1, 32'h11);
    step();
    ifc.EX_RegWre = 1'b0;
    #1; check_eq("prio_mem", ifc.ReadData1, 32'h22);
    step();
    ifc.MEM_RegWre = 1'b0;
    #1; check_eq("prio_wb", ifc.ReadData1, 32'h33);
    step();

    // Load-use: one stall, then forward load data from MEM
    clear_inputs(); ifc.ID_rt = 5'd4; ifc.ID_UseRt = 1'b1;
    ifc.EX_RegWre = 1'b1; ifc.EX_WriteReg = 5'd4; ifc.EX_DBDataSrc = 2'b01;
    #1; check_eq("lu_stall", {31'd0, ifc.Stall}, 32'd1);
    step();
    ifc.EX_RegWre = 1'b0;
    ifc.MEM_RegWre = 1'b1; ifc.MEM_WriteReg = 5'd4; ifc.MEM_DBDataSrc = 2'b01;
    ifc.MEM_MemData = 32'hDEAD_BEEF;
    #1;
    check_eq("lu_nostall", {31'd0, ifc.Stall}, 32'd0);
    check_eq("lu_fwd", ifc.ReadData2, 32'hDEAD_BEEF);
    check_eq("lu_cnt", ifc.StallCount, 32'd1);
    step();
    clear_inputs(); ifc.ID_rt = 5'd4; ifc.ID_UseRt = 1'b0;
    ifc.EX_RegWre = 1'b1; ifc.EX_WriteReg = 5'd4; ifc.EX_DBDataSrc = 2'b01;
    #1; check_eq("lu_unused", {31'd0, ifc.Stall}, 32'd0);
    step();
    ifc.EX_WriteReg = 5'd0; ifc.ID_rt = 5'd0; ifc.ID_UseRt = 1'b1;
    #1; check_eq("lu_r0", {31'd0, ifc.Stall}, 32'd0);
    step();

    // MEM link value
    clear_inputs(); ifc.ID_rs = 5'd31;
    ifc.MEM_RegWre = 1'b1; ifc.MEM_WriteReg = 5'd31; ifc.MEM_DBDataSrc = 2'b10;
    ifc.MEM_PCadd4 = 32'h0000_0040; ifc.MEM_ALUResult = 32'h0000_0999;
    #1; check_eq("mem_link", ifc.ReadData1, 32'h0000_0040);
    step();

    // Randomized traffic over a narrow address range to provoke matches
    clear_inputs();
    for (int c = 0; c < 600; c++) begin
      RST_n = ($urandom_range(0, 63) != 0);
      ifc.ID_rs = 5'($urandom_range(0, 7)); ifc.ID_rt = 5'($urandom_range(0, 7));
      ifc.ID_UseRs = 1'($urandom); ifc.ID_UseRt = 1'($urandom);
      ifc.EX_RegWre = 1'($urandom); ifc.EX_WriteReg = 5'($urandom_range(0, 7));
      ifc.EX_DBDataSrc = 2'($urandom); ifc.EX_ALUResult = $urandom; ifc.EX_PCadd4 = $urandom;
      ifc.MEM_RegWre = 1'($urandom); ifc.MEM_WriteReg = 5'($urandom_range(0, 7));
      ifc.MEM_DBDataSrc = 2'($urandom); ifc.MEM_ALUResult = $urandom;
      ifc.MEM_PCadd4 = $urandom; ifc.MEM_MemData = $urandom;
      ifc.WB_RegWre = 1'($urandom); ifc.WB_WriteReg = 5'($urandom_range(0, 7));
      ifc.WB_WriteData = $urandom;
      step();
    end

    // Reset with a WB write pending: write is dropped, everything cleared
    clear_inputs(); RST_n = 1'b1;
    ifc.WB_RegWre = 1'b1; ifc.WB_WriteReg = 5'd9; ifc.WB_WriteData = 32'h5555_AAAA;
    step();
    ifc.WB_WriteReg = 5'd10; ifc.WB_WriteData = 32'h0BAD_F00D;
    RST_n = 1'b0;
    step();
    RST_n = 1'b1; clear_inputs();
    ifc.ID_rs = 5'd9; ifc.ID_rt = 5'd10;
    #1;
    check_eq("rst_r9", ifc.ReadData1, 32'd0);
    check_eq("rst_r10", ifc.ReadData2, 32'd0);
    check_eq("rst_cnt", ifc.StallCount, 32'd0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode-stage register file and operand-delivery unit: the read-side counterpart of the writeback data selection. Holds the 32×32 general-purpose register array written by the WB stage. Delivers the two source operands to the ID/EX boundary, forwarding in-flight results from EX, MEM and WB. Detects load-use hazards and raises a one-cycle stall.

## Interface
Parameters:
- `NREG`, 32: number of architectural registers; register 0 hardwired to zero.
- `XLEN`, 32: data width.

Ports:
- `CLK`  in  1  clock, rising-edge.
- `RST_n`  in  1  synchronous reset, active-low.
- `ID_rs`, `ID_rt`  in  5  source register addresses of the instruction in ID.
- `ID_UseRs`, `ID_UseRt`  in  1  the instruction in ID actually reads rs / rt.
- `EX_RegWre`  in  1  instruction in EX writes a register.
- `EX_WriteReg`  in  5  its destination.
- `EX_DBDataSrc`  in  2  its writeback source (00 ALU, 01 Mem, 10 PC+4).
- `EX_ALUResult`, `EX_PCadd4`  in  32  its candidate results.
- `MEM_RegWre`, `MEM_WriteReg`, `MEM_DBDataSrc`, `MEM_ALUResult`, `MEM_PCadd4`  in  same as EX: the MEM-stage equivalents.
- `MEM_MemData`  in  32  load data read in MEM, valid in the same cycle.
- `WB_RegWre`  in  1  register write enable from WB.
- `WB_WriteReg`  in  5  WB destination.
- `WB_WriteData`  in  32  selected WB data.
- `ReadData1`, `ReadData2`  out  32  forwarded rs / rt operands.
- `Stall`  out  1  load-use hazard. Hold PC and IF/ID; bubble ID/EX.
- `StallCount`  out  32  saturating count of stall cycles.

## Operation
- Write: on the rising edge, when `WB_RegWre` = 1 and `WB_WriteReg` ≠ 0, the register at `WB_WriteReg` becomes `WB_WriteData`. Writes to register 0 are ignored.
- Operand select for each port (rs shown; rt is identical). The first match wins:
  1. `ID_rs` = 0: output 0.
  2. EX match (`EX_RegWre` = 1, `EX_WriteReg` = `ID_rs`, `EX_DBDataSrc` ≠ 01): output `EX_PCadd4` if the source is 10, else `EX_ALUResult`.
  3. MEM match: output by `MEM_DBDataSrc`, same encoding as writeback: 10 gives `MEM_PCadd4`, 01 gives `MEM_MemData`, otherwise `MEM_ALUResult`.
  4. WB match: output `WB_WriteData`. This is a write-through; the array is not read.
  5. Otherwise: output the array contents.
- Hazard: `Stall` = 1 when `EX_RegWre` = 1, `EX_DBDataSrc` = 01, `EX_WriteReg` ≠ 0, and the register matches (`ID_UseRs` with `ID_rs`) or (`ID_UseRt` with `ID_rt`).
- While stalled, the operand outputs are don't-care; the consumer discards them.
- The encoding 11 is treated as ALU everywhere.
- `StallCount` increments each cycle `Stall` = 1 and saturates at 0xFFFF_FFFF.

## Timing
- Reads and forwarding are combinational, with zero-cycle latency. The write is registered.
- `Stall` is combinational from the inputs. A single load-use produces exactly 1 stall cycle, because the next cycle the load sits in MEM and is forwarded from `MEM_MemData`.
- Reset (`RST_n` = 0 at an edge): all registers become 0 and `StallCount` becomes 0.
  - During reset the outputs follow the combinational rules. The array reads 0 at the first post-reset edge.
  - Reset mid-pipeline discards a WB write that is asserted in the same cycle; reset wins.
- Simultaneous WB write and read of the same register: the read returns the new data (bypass).
- EX and MEM both matching: EX wins (younger instruction).
- A non-load EX match masks an older MEM load to the same register with no stall.
- A load to register 0 in EX never stalls.

## Structure
- Shared package holds:
  - the `DBDataSrc` encodings (`SRC_ALU` = 00, `SRC_MEM` = 01, `SRC_PC4` = 10);
  - the register-address width (5);
  - `XLEN`.
  - Both this block and the writeback selector use these encodings.
- Sub-module `reg_array`: a `NREG`×`XLEN` storage with 2 asynchronous read ports, 1 synchronous write port, synchronous active-low clear, and a zero-register guard.
- Forwarding priority, hazard detection and the counter live in the top level.

## Test plan
- Reset, then write r5 = 0x1234_5678 via WB. The next cycle, with `ID_rs` = 5 and no matches: `ReadData1` = 0x1234_5678. A WB write to r0 of 0xFFFF_FFFF: reading r0 returns 0.
- Same-cycle WB write r7 = 0xA5A5_A5A5 with `ID_rt` = 7: `ReadData2` = 0xA5A5_A5A5 in that cycle.
- EX ALU writes r3 = 0x11, MEM writes r3 = 0x22, WB writes r3 = 0x33, `ID_rs` = 3: output 0x11. Drop EX: output 0x22. Drop MEM: output 0x33.
- EX load to r4 with `ID_rt` = 4 and `ID_UseRt` = 1: `Stall` = 1 for one cycle. Next cycle, MEM load with `MEM_MemData` = 0xDEAD_BEEF: `Stall` = 0, `ReadData2` = 0xDEAD_BEEF, `StallCount` = 1.
  - Same case with `ID_UseRt` = 0: no stall.
- MEM jal-link with `MEM_DBDataSrc` = 10, `MEM_PCadd4` = 0x0000_0040, destination r31, `ID_rs` = 31: output 0x0000_0040.
- Assert `RST_n` = 0 while a WB write is pending: all registers read 0 afterwards and `StallCount` = 0.
